mole_round_ctrl: RTL and testbench

//  Game sequencer for the 4x4 keypad/LED board. Drives one "mole" LED at a time,

---
 rtl/mole_round_ctrl.sv | 121 ++++++++++++
 tb/tb_mole_round_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: lights one LED per round, judges key presses,
// keeps hit/miss/round counts and ends the game after ROUNDS rounds.
module mole_round_ctrl #(
   parameter int unsigned GAP_TICKS = 50_000_000,
   parameter int unsigned ON_TICKS  = 50_000_000,
   parameter int unsigned ROUNDS    = 20,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [15:0] led_out,
   output logic [3:0]  mole_pos,
   output logic [7:0]  score,
   output logic [7:0]  misses,
   output logic [7:0]  round_cnt,
   output logic        busy,
   output logic        game_over
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GAP  = 2'd1;
   localparam logic [1:0] ST_SHOW = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [23:0] GAP_LOAD = 24'(GAP_TICKS - 1);
   localparam logic [23:0] ON_LOAD  = 24'(ON_TICKS - 1);
   localparam logic [7:0]  LAST_RND = 8'(ROUNDS);

   logic [1:0]  state;
   logic [23:0] timer;
   logic [7:0]  lfsr;
   logic        lfsr_fb;
   logic [3:0]  cand;
   logic [3:0]  next_pos;
   logic        hit;
   logic        last_round;
   logic [7:0]  score_inc;
   logic [7:0]  misses_inc;

   // NOTE: every signal written in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
      cand       = lfsr[3:0];
      next_pos   = cand;
      if (cand == mole_pos) next_pos = cand + 4'd1;
      hit        = key_valid && (key_code == mole_pos);
      last_round = ((round_cnt + 8'd1) == LAST_RND);
      score_inc  = (score  == 8'hFF) ? score  : score  + 8'd1;
      misses_inc = (misses == 8'hFF) ? misses : misses + 8'd1;
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order in this block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         timer     <= '0;
         lfsr      <= LFSR_SEED;
         led_out   <= '0;
         mole_pos  <= '0;
         score     <= '0;
         misses    <= '0;
         round_cnt <= '0;
         busy      <= 1'b0;
         game_over <= 1'b0;
      end else begin
         lfsr <= {lfsr[6:0], lfsr_fb};
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_GAP;
                  timer     <= GAP_LOAD;
                  led_out   <= '0;
                  score     <= '0;
                  misses    <= '0;
                  round_cnt <= '0;
                  busy      <= 1'b1;
                  game_over <= 1'b0;
               end
            end
            ST_GAP: begin
               if (timer == '0) begin
                  state    <= ST_SHOW;
                  timer    <= ON_LOAD;
                  mole_pos <= next_pos;
                  led_out  <= 16'b1 << next_pos;
               end else begin
                  timer <= timer - 24'd1;
               end
            end
            ST_SHOW: begin
               timer <= timer - 24'd1;
               // A hit wins over a timeout landing in the same cycle.
               if (hit || timer == '0) begin
                  round_cnt <= round_cnt + 8'd1;
                  if (hit) score  <= score_inc;
                  else     misses <= misses_inc;
                  if (last_round) begin
                     state     <= ST_DONE;
                     led_out   <= 16'hFFFF;
                     busy      <= 1'b0;
                     game_over <= 1'b1;
                  end else begin
                     state   <= ST_GAP;
                     timer   <= GAP_LOAD;
                     led_out <= '0;
                  end
               end else if (key_valid) begin
                  misses <= misses_inc;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Scoreboard bench for mole_round_ctrl: expectations are queued as stimulus is
// driven and compared just after the clock edge that should produce them.
module tb_mole_round_ctrl;

   localparam int         GAP  = 4;
   localparam int         ON   = 8;
   localparam int         RND  = 3;
   localparam logic [7:0] SEED = 8'hA5;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] led_out;
   logic [3:0]  mole_pos;
   logic [7:0]  score;
   logic [7:0]  misses;
   logic [7:0]  round_cnt;
   logic        busy;
   logic        game_over;

   always #5 clk = ~clk;

   mole_round_ctrl #(
      .GAP_TICKS(GAP), .ON_TICKS(ON), .ROUNDS(RND), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
      .key_code(key_code), .led_out(led_out), .mole_pos(mole_pos),
      .score(score), .misses(misses), .round_cnt(round_cnt),
      .busy(busy), .game_over(game_over)
   );

   typedef enum int {S_LED, S_POS, S_SCORE, S_MISS, S_ROUND, S_BUSY, S_OVER} sel_t;
   typedef struct {
      string       tag;
      sel_t        sel;
      logic [15:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [7:0] m_lfsr;
   logic [3:0] exp_pos;
   logic [7:0] exp_score, exp_miss, exp_round;

   // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifting left.
   always @(posedge clk) begin
      if (rst) m_lfsr <= SEED;
      else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] observe(input sel_t s);
      case (s)
         S_LED:   return led_out;
         S_POS:   return {12'b0, mole_pos};
         S_SCORE: return {8'b0, score};
         S_MISS:  return {8'b0, misses};
         S_ROUND: return {8'b0, round_cnt};
         S_BUSY:  return {15'b0, busy};
         default: return {15'b0, game_over};
      endcase
   endfunction

   task automatic push(input string tag, input sel_t s, input logic [15:0] v);
      exp_t e;
      e.tag = tag; e.sel = s; e.exp = v;
      sb.push_back(e);
   endtask

   task automatic push_stats(input string tag);
      push({tag, ".score"}, S_SCORE, {8'b0, exp_score});
      push({tag, ".misses"}, S_MISS, {8'b0, exp_miss});
      push({tag, ".round"}, S_ROUND, {8'b0, exp_round});
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      start     = 1'b0;
      key_valid = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic start_game(input string tag);
      start     = 1'b1;
      exp_score = 0; exp_miss = 0; exp_round = 0;
      push({tag, ".led"}, S_LED, 16'h0);
      push({tag, ".busy"}, S_BUSY, 16'h1);
      push({tag, ".over"}, S_OVER, 16'h0);
      push_stats(tag);
      step();
   endtask

   // GAP state was entered at the previous edge; 3 more dark cycles, then a mole.
   task automatic gap_phase(input bit poke);
      logic [3:0] cand;
      logic [3:0] prev;
      for (int i = 0; i < GAP - 1; i++) begin
         if (poke && i == 0) begin
            key_valid = 1'b1;
            key_code  = exp_pos;
         end
         push("gap.led", S_LED, 16'h0);
         push("gap.busy", S_BUSY, 16'h1);
         push_stats("gap");
         step();
      end
      cand    = m_lfsr[3:0];
      prev    = exp_pos;
      exp_pos = (cand == prev) ? cand + 4'd1 : cand;
      push("lit.led", S_LED, 16'h1 << exp_pos);
      push("lit.pos", S_POS, {12'b0, exp_pos});
      push("lit.busy", S_BUSY, 16'h1);
      step();
      check("mole_changed", {15'b0, mole_pos != prev}, 16'h1);
   endtask

   task automatic show_hold(input int n);
      for (int i = 0; i < n; i++) begin
         push("show.led", S_LED, 16'h1 << exp_pos);
         push("show.pos", S_POS, {12'b0, exp_pos});
         push_stats("show");
         step();
      end
   endtask

   task automatic finish_round(input bit is_hit);
      if (is_hit) begin
         key_valid = 1'b1;
         key_code  = exp_pos;
         exp_score++;
      end else begin
         exp_miss++;
      end
      exp_round++;
      if (exp_round == RND) begin
         push("end.led", S_LED, 16'hFFFF);
         push("end.busy", S_BUSY, 16'h0);
         push("end.over", S_OVER, 16'h1);
      end else begin
         push("end.led", S_LED, 16'h0);
         push("end.busy", S_BUSY, 16'h1);
         push("end.over", S_OVER, 16'h0);
      end
      push_stats("end");
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_code = 4'd0;
      exp_pos = 0; exp_score = 0; exp_miss = 0; exp_round = 0;
      step();
      push("rst.led", S_LED, 16'h0);
      push("rst.pos", S_POS, 16'h0);
      push("rst.busy", S_BUSY, 16'h0);
      push("rst.over", S_OVER, 16'h0);
      push_stats("rst");
      step();
      rst = 1'b0;
      push("idle.busy", S_BUSY, 16'h0);
      step();

      // Game 1, round 1: hit two cycles after the LED lights.
      start_game("start1");
      gap_phase(1'b0);
      show_hold(1);
      finish_round(1'b1);

      // Round 2: wrong key at once, then timeout after the full ON period.
      gap_phase(1'b0);
      key_valid = 1'b1;
      key_code  = exp_pos ^ 4'h1;
      exp_miss++;
      show_hold(1);
      show_hold(ON - 2);
      finish_round(1'b0);

      // Round 3: correct key in the timer==0 cycle, ends the game.
      gap_phase(1'b0);
      show_hold(ON - 1);
      finish_round(1'b1);

      // DONE holds its counts and ignores keys.
      key_valid = 1'b1;
      key_code  = exp_pos;
      push("done.led", S_LED, 16'hFFFF);
      push("done.over", S_OVER, 16'h1);
      push_stats("done");
      step();

      // Restart from DONE; a key during GAP is ignored.
      start_game("start2");
      gap_phase(1'b1);

      // start during SHOW is ignored, then reset mid-SHOW.
      start = 1'b1;
      push("ign_start.led", S_LED, 16'h1 << exp_pos);
      push("ign_start.busy", S_BUSY, 16'h1);
      push_stats("ign_start");
      step();
      rst = 1'b1;
      exp_pos = 0; exp_score = 0; exp_miss = 0; exp_round = 0;
      push("rst2.led", S_LED, 16'h0);
      push("rst2.pos", S_POS, 16'h0);
      push("rst2.busy", S_BUSY, 16'h0);
      push("rst2.over", S_OVER, 16'h0);
      push_stats("rst2");
      step();
      rst = 1'b0;

      // Full game of timeouts; each mole must differ from the previous one.
      start_game("start3");
      for (int r = 0; r < RND; r++) begin
         gap_phase(1'b0);
         show_hold(ON - 1);
         finish_round(1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
